// File: rtl/instr_fetch.sv
// Instruction fetch stage: synchronous ROM read into an instruction register,
// with stall/flush control, out-of-range fault detection and field decode.
module instr_fetch #(
  parameter int          BUS_WIDTH = 16,
  parameter int          DEPTH     = 256,
  parameter string       INIT_FILE = "imem.hex",
  parameter logic [15:0] NOP       = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] instr_addr,
  input  logic                 stall,
  input  logic                 flush,
  output logic [BUS_WIDTH-1:0] ir,
  output logic [BUS_WIDTH-1:0] ir_addr,
  output logic                 ir_valid,
  output logic [6:0]           opcode,
  output logic [2:0]           dr,
  output logic [2:0]           sa,
  output logic [2:0]           sb,
  output logic [5:0]           offset,
  output logic                 addr_fault
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_KILL = 2'd3
  } state_t;

  // NOTE: the ROM is deliberately left out of reset; only the pipeline
  // registers reset, so the array maps onto block RAM and keeps its image.
  logic [BUS_WIDTH-1:0] mem [DEPTH];

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] ir_q, ir_d;
  logic [BUS_WIDTH-1:0] ir_addr_q, ir_addr_d;
  logic                 ir_valid_q, ir_valid_d;
  logic                 fault_q, fault_d;
  logic                 in_range;
  logic [BUS_WIDTH-1:0] rom_word;

  // Any address bit above the ROM index makes the fetch out of range.
  generate
    if (BUS_WIDTH > ADDR_W) begin : g_range_chk
      assign in_range = ~|instr_addr[BUS_WIDTH-1:ADDR_W];
    end else begin : g_range_full
      assign in_range = 1'b1;
    end
  endgenerate

  assign rom_word = mem[instr_addr[ADDR_W-1:0]];

  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_addr_d  = ir_addr_q;
    ir_valid_d = ir_valid_q;
    fault_d    = fault_q;

    if (flush) begin
      state_d    = S_KILL;
      ir_d       = NOP[BUS_WIDTH-1:0];
      ir_addr_d  = instr_addr;
      ir_valid_d = 1'b0;
    end else if (stall) begin
      state_d = S_HOLD;
    end else begin
      state_d   = S_RUN;
      ir_addr_d = instr_addr;
      if (!in_range) begin
        ir_d       = NOP[BUS_WIDTH-1:0];
        ir_valid_d = 1'b0;
        fault_d    = 1'b1;
      end else begin
        ir_d = rom_word;
        // The first load after reset is a bubble; HOLD and KILL resume as RUN.
        ir_valid_d = (state_q != S_BOOT);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_BOOT;
      ir_q       <= NOP[BUS_WIDTH-1:0];
      ir_addr_q  <= '0;
      ir_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_addr_q  <= ir_addr_d;
      ir_valid_q <= ir_valid_d;
      fault_q    <= fault_d;
    end
  end

  assign ir         = ir_q;
  assign ir_addr    = ir_addr_q;
  assign ir_valid   = ir_valid_q;
  assign addr_fault = fault_q;

  assign opcode = ir_q[15:9];
  assign dr     = ir_q[8:6];
  assign sa     = ir_q[5:3];
  assign sb     = ir_q[2:0];
  assign offset = {ir_q[8:6], ir_q[2:0]};

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: boot bubble, decode, stall, flush,
// address fault, and asynchronous reset during a stall.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr_addr;
  logic        stall;
  logic        flush;
  logic [15:0] ir;
  logic [15:0] ir_addr;
  logic        ir_valid;
  logic [6:0]  opcode;
  logic [2:0]  dr;
  logic [2:0]  sa;
  logic [2:0]  sb;
  logic [5:0]  offset;
  logic        addr_fault;

  int n_asserts = 0;
  int n_fail    = 0;

  instr_fetch #(
    .BUS_WIDTH (16),
    .DEPTH     (256),
    .INIT_FILE (""),
    .NOP       (16'h0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_addr (instr_addr),
    .stall      (stall),
    .flush      (flush),
    .ir         (ir),
    .ir_addr    (ir_addr),
    .ir_valid   (ir_valid),
    .opcode     (opcode),
    .dr         (dr),
    .sa         (sa),
    .sb         (sb),
    .offset     (offset),
    .addr_fault (addr_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] e_ir,
                           input logic [15:0] e_addr, input logic e_valid,
                           input logic e_fault);
    check({tag, ".ir"},       ir,                 e_ir);
    check({tag, ".ir_addr"},  ir_addr,            e_addr);
    check({tag, ".ir_valid"}, {15'd0, ir_valid},  {15'd0, e_valid});
    check({tag, ".fault"},    {15'd0, addr_fault}, {15'd0, e_fault});
  endtask

  // Drive inputs on the falling edge, then step through one rising edge.
  task automatic step(input logic [15:0] a, input logic s, input logic f);
    instr_addr = a;
    stall      = s;
    flush      = f;
    @(negedge clk);
  endtask

  initial begin
    // ROM image: three named words, the rest tagged C000 | address.
    for (int i = 0; i < 256; i++) dut.mem[i] = 16'hC000 | 16'(i);
    dut.mem[0] = 16'h1234;
    dut.mem[1] = 16'hA5C3;
    dut.mem[2] = 16'h8042;

    reset = 1'b0; instr_addr = 16'h0000; stall = 1'b0; flush = 1'b0;
    #2;
    check_out("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    step(16'h0000, 1'b0, 1'b0);
    check_out("boot", 16'h1234, 16'h0000, 1'b0, 1'b0);

    step(16'h0001, 1'b0, 1'b0);
    check_out("run1", 16'hA5C3, 16'h0001, 1'b1, 1'b0);
    check("run1.opcode", {9'd0, opcode}, 16'h0052);
    check("run1.dr",     {13'd0, dr},    16'h0007);
    check("run1.sa",     {13'd0, sa},    16'h0000);
    check("run1.sb",     {13'd0, sb},    16'h0003);
    check("run1.offset", {10'd0, offset}, 16'h003B);

    step(16'h0002, 1'b0, 1'b0);
    check_out("run2", 16'h8042, 16'h0002, 1'b1, 1'b0);
    check("run2.opcode", {9'd0, opcode}, 16'h0040);
    check("run2.dr",     {13'd0, dr},    16'h0001);
    check("run2.offset", {10'd0, offset}, 16'h000A);

    // Three stalled cycles while the PC keeps moving.
    step(16'h0003, 1'b1, 1'b0);
    check_out("stall1", 16'h8042, 16'h0002, 1'b1, 1'b0);
    step(16'h0004, 1'b1, 1'b0);
    check_out("stall2", 16'h8042, 16'h0002, 1'b1, 1'b0);
    step(16'h0005, 1'b1, 1'b0);
    check_out("stall3", 16'h8042, 16'h0002, 1'b1, 1'b0);
    step(16'h0005, 1'b0, 1'b0);
    check_out("unstall", 16'hC005, 16'h0005, 1'b1, 1'b0);

    step(16'h0003, 1'b0, 1'b1);
    check_out("flush", 16'h0000, 16'h0003, 1'b0, 1'b0);
    step(16'h0004, 1'b0, 1'b0);
    check_out("post_flush", 16'hC004, 16'h0004, 1'b1, 1'b0);

    step(16'h0006, 1'b1, 1'b1);
    check_out("flush_stall", 16'h0000, 16'h0006, 1'b0, 1'b0);
    step(16'h0007, 1'b0, 1'b0);
    check_out("post_fs", 16'hC007, 16'h0007, 1'b1, 1'b0);

    step(16'hF0F0, 1'b0, 1'b0);
    check_out("oor", 16'h0000, 16'hF0F0, 1'b0, 1'b1);
    step(16'h0000, 1'b0, 1'b0);
    check_out("post_oor", 16'h1234, 16'h0000, 1'b1, 1'b1);
    step(16'h00FF, 1'b0, 1'b0);
    check_out("top_word", 16'hC0FF, 16'h00FF, 1'b1, 1'b1);

    // Reset in the middle of a stalled cycle, between clock edges.
    step(16'h0001, 1'b1, 1'b0);
    check_out("hold_pre_rst", 16'hC0FF, 16'h00FF, 1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_out("async_rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check_out("rst_held", 16'h0000, 16'h0000, 1'b0, 1'b0);

    reset = 1'b1;
    step(16'h0002, 1'b0, 1'b0);
    check_out("reboot", 16'h8042, 16'h0002, 1'b0, 1'b0);
    step(16'h0003, 1'b0, 1'b0);
    check_out("rerun", 16'hC003, 16'h0003, 1'b1, 1'b0);

    // PC wrap lands on address 0: a plain fetch, no fault.
    step(16'h0000, 1'b0, 1'b0);
    check_out("wrap", 16'h1234, 16'h0000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
